// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: decoded fields in, encoded word plus
// instruction-memory address out, each side with its own valid/ready pair.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  immSrc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [31:0] imm32;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  modport master (
    output in_valid, immSrc, opcode, rd, rs1, rs2, funct3, imm32, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err, err_count
  );

  modport slave (
    input  in_valid, immSrc, opcode, rd, rs1, rs2, funct3, imm32, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs RV32I fields + immediate into an instruction word (inverse of immSrc extraction),
// range-checks the immediate and presents words with sequential addresses.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic clk,
  input  logic reset,
  instr_encoder_if.slave bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state;
  logic [31:0] instr_q, addr_q, imm, enc_word;
  logic [7:0]  cnt_q;
  logic        err_q, legal, in_fire, out_fire;

  assign imm      = bus.imm32;
  // reset term keeps in_ready high while the state register is being cleared
  assign bus.in_ready = reset || (state == EMPTY) || bus.out_ready;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = (state == FULL) && bus.out_ready;

  assign bus.out_valid = (state == FULL);
  assign bus.out_instr = instr_q;
  assign bus.out_addr  = addr_q;
  assign bus.out_err   = err_q;
  assign bus.err_count = cnt_q;

  always_comb begin
    enc_word = NOP;
    legal    = 1'b0;
    case (bus.immSrc)
      3'b000: begin
        legal    = (&imm[31:11]) || !(|imm[31:11]);
        enc_word = {imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
      end
      3'b001: begin
        legal    = (&imm[31:11]) || !(|imm[31:11]);
        enc_word = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], bus.opcode};
      end
      3'b010: begin
        legal    = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
        enc_word = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                    imm[4:1], imm[11], bus.opcode};
      end
      3'b011: begin
        legal    = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, bus.opcode};
      end
      3'b100: begin
        legal    = !(|imm[11:0]);
        enc_word = {imm[31:12], bus.rd, bus.opcode};
      end
      default: begin
        legal    = 1'b0;
        enc_word = NOP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      instr_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= BASE_ADDR;
      cnt_q   <= '0;
    end else begin
      // address tracks words consumed, so a reload on the same edge sees old+4
      if (out_fire) addr_q <= addr_q + 32'd4;
      case (state)
        EMPTY: if (in_fire) state <= FULL;
        FULL:  if (out_fire && !in_fire) state <= EMPTY;
      endcase
      if (in_fire) begin
        instr_q <= legal ? enc_word : NOP;
        err_q   <= !legal;
        if (!legal && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized + directed bench for instr_encoder against a bit-placement/range-check
// reference model and a queue scoreboard of pending words.
module tb_instr_encoder;
  localparam logic [31:0] BASE = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_encoder_if bus();
  instr_encoder #(.BASE_ADDR(BASE)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { logic [31:0] instr; logic err; } exp_t;
  exp_t        q[$];
  int          n_tests = 0, n_fail = 0;
  int          n_out = 0, exp_cnt = 0;
  logic        force_k = 1'b0;
  logic [31:0] k_word = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference: plain bit arithmetic and signed range tests
  function automatic logic [32:0] ref_enc(input logic [2:0] s, input logic [6:0] op,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [2:0] f3, input logic [31:0] imm);
    int si;
    bit ok;
    logic [31:0] w;
    si = imm;
    ok = 0;
    w  = 0;
    case (s)
      3'd0: begin
        ok = si >= -2048 && si <= 2047;
        w = ((imm & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'(op);
      end
      3'd1: begin
        ok = si >= -2048 && si <= 2047;
        w = (((imm >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12)
          | ((imm & 32'h1F) << 7) | 32'(op);
      end
      3'd2: begin
        ok = si >= -4096 && si <= 4095 && (imm % 2) == 0;
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(s2) << 20)
          | (32'(s1) << 15) | (32'(f3) << 12) | (((imm >> 1) & 32'hF) << 8)
          | (((imm >> 11) & 1) << 7) | 32'(op);
      end
      3'd3: begin
        ok = si >= -(1 << 20) && si < (1 << 20) && (imm % 2) == 0;
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 1) << 20)
          | (((imm >> 12) & 32'hFF) << 12) | (32'(d) << 7) | 32'(op);
      end
      3'd4: begin
        ok = (imm % 4096) == 0;
        w = (imm & 32'hFFFF_F000) | (32'(d) << 7) | 32'(op);
      end
      default: ok = 0;
    endcase
    if (!ok) w = 32'h0000_0013;
    return {!ok, w};
  endfunction

  task automatic req(input logic [2:0] s, input logic [6:0] op, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] imm);
    bus.in_valid = 1'b1;
    bus.immSrc = s; bus.opcode = op; bus.rd = d; bus.rs1 = s1; bus.rs2 = s2;
    bus.funct3 = f3; bus.imm32 = imm;
  endtask

  task automatic rnd_req();
    int v;
    case ($urandom_range(0, 3))
      0: v = int'($urandom_range(0, 8191)) - 4096;
      1: v = int'($urandom & 32'hFFFF_F000);
      2: v = int'($urandom);
      default: v = int'($urandom_range(0, 2097151)) - 1048576;
    endcase
    if ($urandom_range(0, 1) == 1) v = v & ~1;
    req(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
        3'($urandom), 32'(v));
  endtask

  // one clock: inputs already driven after a negedge
  task automatic cycle();
    logic ifire, ofire;
    logic [32:0] r;
    exp_t e;
    #1;
    chk("in_ready", bus.in_ready, q.size() == 0 || bus.out_ready);
    ifire = bus.in_valid && (q.size() == 0 || bus.out_ready);
    ofire = q.size() > 0 && bus.out_ready;
    r = ref_enc(bus.immSrc, bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.funct3, bus.imm32);
    @(posedge clk);
    if (ofire) begin void'(q.pop_front()); n_out++; end
    if (ifire) begin
      e.instr = force_k ? k_word : r[31:0];
      e.err = r[32];
      q.push_back(e);
      if (r[32] && exp_cnt < 255) exp_cnt++;
    end
    #1;
    chk("out_valid", bus.out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_instr", bus.out_instr, q[0].instr);
      chk("out_err", bus.out_err, q[0].err);
      chk("out_addr", bus.out_addr, BASE + 32'(n_out * 4));
    end
    chk("err_count", bus.err_count, 32'(exp_cnt));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("in_ready_in_reset", bus.in_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete(); n_out = 0; exp_cnt = 0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_instr", bus.out_instr, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_out_addr", bus.out_addr, BASE);
    chk("rst_err_count", bus.err_count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
  endtask

  task automatic dir(input logic [31:0] k, input logic [2:0] s, input logic [6:0] op,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
      input logic [31:0] imm);
    req(s, op, d, s1, s2, f3, imm);
    force_k = 1'b1; k_word = k;
    cycle();
    force_k = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    bus.in_valid = 1'b0;
    do_reset();

    // directed encodings, back-to-back; addresses wrap past FFFF_FFFC
    bus.out_ready = 1'b1;
    dir(32'h0050_0093, 3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    dir(32'h0021_A423, 3'd1, 7'b0100011, 5'd0, 5'd3, 5'd2, 3'b010, 32'd8);
    dir(32'h1234_52B7, 3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
    dir(32'hFE00_0EE3, 3'd2, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC);
    dir(32'h0010_00EF, 3'd3, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800);

    // illegal requests
    dir(32'h0000_0013, 3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    dir(32'h0000_0013, 3'd2, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3);
    dir(32'h0000_0013, 3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h0000_0800);
    dir(32'h0000_0013, 3'd7, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0);
    chk("err_count_after_4", bus.err_count, 4);
    bus.in_valid = 1'b0;
    cycle();

    // backpressure: FULL, out_ready low for 5 cycles with requests offered
    req(3'd0, 7'b0010011, 5'd7, 5'd6, 5'd0, 3'd0, 32'd100);
    cycle();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rnd_req();
      cycle();
    end
    bus.out_ready = 1'b1;
    req(3'd1, 7'b0100011, 5'd0, 5'd9, 5'd10, 3'b010, 32'hFFFF_FFF0);
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    cycle();

    // randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) rnd_req(); else bus.in_valid = 1'b0;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    // saturation of err_count
    bus.out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      req(3'($urandom_range(5, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
          3'($urandom), $urandom);
      cycle();
    end
    chk("err_count_saturated", bus.err_count, 255);
    bus.in_valid = 1'b0;
    cycle();

    // reset while FULL and stalled
    req(3'd4, 7'b0110111, 5'd3, 5'd0, 5'd0, 3'd0, 32'hABCD_E000);
    cycle();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    cycle();
    req(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
    do_reset();
    bus.in_valid = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
